// File: rtl/image_writer.sv
// Single-frame capture buffer: accepts a raster stream of NUMPIXELS pixels after
// a start pulse and exposes the stored frame through a registered read port.
module image_writer #(
   parameter  int NUMPIXELS  = 1024,
   parameter  int PIXELWIDTH = 8,
   localparam int ADDRW      = $clog2(NUMPIXELS),
   localparam int CNTW       = ADDRW + 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  pix_valid,
   input  logic [PIXELWIDTH-1:0] pix_data,
   output logic                  pix_ready,
   input  logic [ADDRW-1:0]      rd_addr,
   output logic [PIXELWIDTH-1:0] rd_data,
   output logic                  busy,
   output logic                  done,
   output logic [CNTW-1:0]       count
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CAPTURE = 2'd1,
      DONE    = 2'd2
   } state_t;

   localparam logic [CNTW-1:0] NPIX = CNTW'(NUMPIXELS);
   localparam logic [CNTW-1:0] LAST = CNTW'(NUMPIXELS - 1);

   state_t                state_q, state_d;
   logic [CNTW-1:0]       count_q, count_d;
   logic [PIXELWIDTH-1:0] rd_data_q, rd_data_d;
   logic                  mem_we;
   logic [ADDRW-1:0]      waddr;

   // Frame buffer is deliberately not reset.
   logic [PIXELWIDTH-1:0] mem_q [NUMPIXELS];

   assign waddr = count_q[ADDRW-1:0];

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      mem_we  = 1'b0;
      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               state_d = CAPTURE;
               count_d = '0;
            end
         end
         CAPTURE: begin
            // start is ignored mid-frame; only transfers advance the pointer.
            if (pix_valid) begin
               mem_we  = 1'b1;
               count_d = count_q + 1'b1;
               if (count_q == LAST) state_d = DONE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Out-of-range reads return zero rather than aliasing into the buffer.
   always_comb begin
      rd_data_d = '0;
      if ({1'b0, rd_addr} < NPIX) rd_data_d = mem_q[rd_addr];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         count_q   <= '0;
         rd_data_q <= '0;
      end else begin
         state_q   <= state_d;
         count_q   <= count_d;
         rd_data_q <= rd_data_d;
      end
   end

   always_ff @(posedge clk) begin
      if (mem_we) mem_q[waddr] <= pix_data;
   end

   assign pix_ready = (state_q == CAPTURE);
   assign busy      = (state_q == CAPTURE);
   assign done      = (state_q == DONE);
   assign count     = count_q;
   assign rd_data   = rd_data_q;

endmodule

// File: tb/tb_image_writer.sv
// Directed bench for image_writer: a behavioural frame model plus a readback
// scoreboard queue, checked with immediate assertions every cycle.
module tb_image_writer;

   localparam int N  = 16;
   localparam int W  = 8;
   localparam int AW = 4;
   localparam int CW = 5;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic          pix_valid = 1'b0;
   logic [W-1:0]  pix_data = '0;
   logic [AW-1:0] rd_addr = '0;
   logic          pix_ready, busy, done;
   logic [W-1:0]  rd_data;
   logic [CW-1:0] count;

   logic          start2 = 1'b0;
   logic          pix_valid2 = 1'b0;
   logic [W-1:0]  pix_data2 = '0;
   logic [3:0]    rd_addr2 = '0;
   logic          pix_ready2, busy2, done2;
   logic [W-1:0]  rd_data2;
   logic [4:0]    count2;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   image_writer #(.NUMPIXELS(N), .PIXELWIDTH(W)) dut (
      .clk(clk), .rst(rst), .start(start), .pix_valid(pix_valid),
      .pix_data(pix_data), .pix_ready(pix_ready), .rd_addr(rd_addr),
      .rd_data(rd_data), .busy(busy), .done(done), .count(count)
   );

   image_writer #(.NUMPIXELS(10), .PIXELWIDTH(W)) dut10 (
      .clk(clk), .rst(rst), .start(start2), .pix_valid(pix_valid2),
      .pix_data(pix_data2), .pix_ready(pix_ready2), .rd_addr(rd_addr2),
      .rd_data(rd_data2), .busy(busy2), .done(done2), .count(count2)
   );

   // Reference model of the main instance
   typedef enum {M_IDLE, M_CAP, M_DONE} mst_t;
   mst_t         m_state = M_IDLE;
   int           m_cnt = 0;
   logic [W-1:0] m_mem [N];
   bit           m_known [N];
   logic [W-1:0] exp_q [$];
   bit           kn_q [$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_ctrl();
      check("busy", busy, m_state == M_CAP);
      check("pix_ready", pix_ready, m_state == M_CAP);
      check("done", done, m_state == M_DONE);
      check("count", count, m_cnt);
   endtask

   // One clock: push expected readback, advance model, wait edge, pop and compare.
   task automatic tick();
      logic [W-1:0] e;
      bit           k;
      k = rst ? 1'b1 : m_known[rd_addr];
      e = rst ? '0 : m_mem[rd_addr];
      exp_q.push_back(e);
      kn_q.push_back(k);
      if (rst) begin
         m_state = M_IDLE;
         m_cnt   = 0;
      end else begin
         case (m_state)
            M_IDLE, M_DONE: if (start) begin m_state = M_CAP; m_cnt = 0; end
            M_CAP: if (pix_valid) begin
               m_mem[m_cnt]   = pix_data;
               m_known[m_cnt] = 1'b1;
               m_cnt++;
               if (m_cnt == N) m_state = M_DONE;
            end
            default: m_state = M_IDLE;
         endcase
      end
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      k = kn_q.pop_front();
      if (k) check("rd_data", rd_data, e);
      check_ctrl();
   endtask

   task automatic readback();
      for (int a = 0; a < N; a++) begin
         rd_addr = AW'(a);
         tick();
      end
   endtask

   task automatic frame(input logic [W-1:0] base, input bit same);
      for (int i = 0; i < N; i++) begin
         pix_valid = 1'b1;
         pix_data  = same ? base : base + W'(i);
         tick();
      end
      pix_valid = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < N; i++) m_known[i] = 1'b0;

      // Reset state
      #2;
      check("rst_rd_data", rd_data, 0);
      check_ctrl();
      #10 rst = 1'b0;
      @(posedge clk);
      #1;
      tick();

      // Basic frame 0x10..0x1F
      start = 1'b1;
      tick();
      start = 1'b0;
      check("ready_after_start", pix_ready, 1);
      frame(8'h10, 1'b0);
      check("done_after_frame", done, 1);
      check("count_full", count, N);
      readback();

      // Same-address read during write returns old contents
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         pix_valid = 1'b1;
         pix_data  = 8'h20 + W'(i);
         tick();
      end
      rd_addr   = 4'd3;
      pix_data  = 8'h55;
      tick();
      check("rw_collision_old", rd_data, 8'h13);
      pix_valid = 1'b0;
      tick();
      check("rw_collision_new", rd_data, 8'h55);

      // Remaining pixels with sparse valid and a start mid-frame
      for (int c = 0; c < 200 && m_state != M_DONE; c++) begin
         pix_valid = (c % 3 == 0);
         pix_data  = 8'h40 + W'(m_cnt);
         start     = pix_valid && (m_cnt == 5);
         tick();
      end
      start = 1'b0;
      pix_valid = 1'b0;
      check("sparse_done", done, 1);
      readback();

      // Async reset mid-frame
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 7; i++) begin
         pix_valid = 1'b1;
         pix_data  = 8'h70 + W'(i);
         tick();
      end
      #2 rst = 1'b1;
      m_state = M_IDLE;
      m_cnt   = 0;
      #1;
      check("async_busy", busy, 0);
      check("async_ready", pix_ready, 0);
      check("async_count", count, 0);
      check("async_rd_data", rd_data, 0);
      tick();
      #3 rst = 1'b0;
      pix_valid = 1'b1;
      pix_data  = 8'h77;
      for (int i = 0; i < 4; i++) tick();
      check("no_write_idle", count, 0);
      start = 1'b1;
      tick();
      start = 1'b0;
      frame(8'h60, 1'b0);
      readback();

      // DONE ignores pix_valid, then restart with 0xAA frame
      pix_valid = 1'b1;
      pix_data  = 8'hAA;
      for (int i = 0; i < 10; i++) tick();
      check("done_hold_count", count, N);
      readback();
      start = 1'b1;
      tick();
      start = 1'b0;
      check("restart_count", count, 0);
      check("restart_busy", busy, 1);
      frame(8'hAA, 1'b1);
      readback();

      // NUMPIXELS=10 instance: out-of-range read and short frame
      rd_addr2 = 4'd12;
      tick();
      check("n10_oob_read", rd_data2, 0);
      start2 = 1'b1;
      tick();
      start2 = 1'b0;
      for (int i = 0; i < 10; i++) begin
         pix_valid2 = 1'b1;
         pix_data2  = 8'h80 + W'(i);
         tick();
         if (i == 8) check("n10_count9", count2, 9);
      end
      pix_valid2 = 1'b0;
      check("n10_count", count2, 10);
      check("n10_done", done2, 1);
      check("n10_ready_low", pix_ready2, 0);
      rd_addr2 = 4'd9;
      tick();
      check("n10_read9", rd_data2, 8'h89);
      rd_addr2 = 4'd12;
      tick();
      check("n10_oob_after", rd_data2, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
